// File: rtl/tag_sequencer.sv
// Tag inventory/access sequencer.
// Decodes parsed commands into state, slot and reply requests.
module tag_sequencer (
  input  logic        bitclk,
  input  logic        reset,
  input  logic [8:0]  cmd_in,
  input  logic        packet_complete,
  input  logic        crc_ok,
  input  logic        rn_match,
  input  logic [3:0]  q_in,
  input  logic [15:0] rng_in,
  input  logic        tx_done,
  output logic [2:0]  state,
  output logic [14:0] slot,
  output logic        tx_start,
  output logic [2:0]  tx_sel,
  output logic        tx_busy,
  output logic        rx_reset
);

  localparam logic [2:0] S_READY = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_REPLY = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_OPEN  = 3'd4;

  localparam logic [2:0] TX_RN16  = 3'd0;
  localparam logic [2:0] TX_EPC   = 3'd1;
  localparam logic [2:0] TX_HNDL  = 3'd2;
  localparam logic [2:0] TX_RDATA = 3'd3;
  localparam logic [2:0] TX_WACK  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [14:0] slot_q, slot_d;
  logic        start_q, start_d;
  logic [2:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        rxr_q, rxr_d;
  logic        pc_q;

  logic        pkt_ev;
  logic        one_hot;
  logic        cmd_ok;
  logic [15:0] mask;
  logic [15:0] ns_full;
  logic [14:0] dec_slot;
  logic        go_tx;
  logic [2:0]  go_sel;

  assign pkt_ev   = packet_complete & ~pc_q;
  assign one_hot  = (cmd_in != 9'd0) &&
                    ((cmd_in & (cmd_in - 9'd1)) == 9'd0);
  assign cmd_ok   = pkt_ev & crc_ok & one_hot & ~busy_q;
  assign mask     = (16'd1 << q_in) - 16'd1;
  assign ns_full  = rng_in & mask;
  assign dec_slot = slot_q - 15'd1;

  // State register: all sequencer state, reset wins over everything
  always_ff @(posedge bitclk) begin
    if (reset) begin
      state_q <= S_READY;
      slot_q  <= 15'd0;
      start_q <= 1'b0;
      sel_q   <= TX_RN16;
      busy_q  <= 1'b0;
      rxr_q   <= 1'b0;
      pc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      start_q <= start_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      rxr_q   <= rxr_d;
      pc_q    <= packet_complete;
    end
  end

  // Next-state decode of an accepted command
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    go_tx   = 1'b0;
    go_sel  = TX_RN16;
    if (cmd_ok) begin
      unique case (1'b1)
        cmd_in[0]: begin
          if (state_q == S_ARB) begin
            slot_d = dec_slot;
            if (dec_slot == 15'd0) begin
              state_d = S_REPLY;
              go_tx   = 1'b1;
            end
          end else if (state_q == S_REPLY) begin
            state_d = S_ARB;
            slot_d  = 15'h7FFF;
          end else if (state_q == S_ACK ||
                       state_q == S_OPEN) begin
            state_d = S_READY;
          end
        end
        cmd_in[1]: begin
          if (rn_match &&
              (state_q == S_REPLY || state_q == S_ACK)) begin
            state_d = S_ACK;
            go_tx   = 1'b1;
            go_sel  = TX_EPC;
          end else if (state_q == S_REPLY) begin
            state_d = S_ARB;
          end
        end
        cmd_in[2], cmd_in[3]: begin
          if (cmd_in[2] || state_q == S_ARB ||
              state_q == S_REPLY) begin
            slot_d = ns_full[14:0];
            if (ns_full == 16'd0) begin
              state_d = S_REPLY;
              go_tx   = 1'b1;
            end else begin
              state_d = S_ARB;
            end
          end else if (state_q == S_ACK ||
                       state_q == S_OPEN) begin
            state_d = S_READY;
          end
        end
        cmd_in[4]: state_d = S_READY;
        cmd_in[5]: begin
          if (state_q == S_REPLY || state_q == S_ACK ||
              state_q == S_OPEN) begin
            state_d = S_ARB;
          end
        end
        cmd_in[6]: begin
          if (rn_match && state_q == S_ACK) begin
            state_d = S_OPEN;
            go_tx   = 1'b1;
            go_sel  = TX_HNDL;
          end else if (rn_match && state_q == S_OPEN) begin
            go_tx   = 1'b1;
          end
        end
        cmd_in[7], cmd_in[8]: begin
          if (rn_match && state_q == S_OPEN) begin
            go_tx  = 1'b1;
            go_sel = cmd_in[7] ? TX_RDATA : TX_WACK;
          end
        end
        default: ;
      endcase
    end
  end

  // Output/handshake next values: reply pulse, held selector, busy, rearm
  always_comb begin
    start_d = go_tx;
    sel_d   = go_tx ? go_sel : sel_q;
    rxr_d   = pkt_ev;
    busy_d  = busy_q;
    if (start_q)
      busy_d = 1'b1;
    else if (busy_q && tx_done)
      busy_d = 1'b0;
  end

  assign state    = state_q;
  assign slot     = slot_q;
  assign tx_start = start_q;
  assign tx_sel   = sel_q;
  assign tx_busy  = busy_q;
  assign rx_reset = rxr_q;

endmodule

// File: tb/tb_tag_sequencer.sv
// Bench for tag_sequencer: cycle model plus directed scenarios.
// Model compares every cycle; literal checks pin key points.
module tb_tag_sequencer;

  logic        bitclk = 1'b0;
  logic        reset;
  logic [8:0]  cmd_in;
  logic        packet_complete;
  logic        crc_ok;
  logic        rn_match;
  logic [3:0]  q_in;
  logic [15:0] rng_in;
  logic        tx_done;
  logic [2:0]  state;
  logic [14:0] slot;
  logic        tx_start;
  logic [2:0]  tx_sel;
  logic        tx_busy;
  logic        rx_reset;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [8:0] QREP = 9'h001, ACK  = 9'h002;
  localparam logic [8:0] QRY  = 9'h004, QADJ = 9'h008;
  localparam logic [8:0] SEL  = 9'h010, NAK  = 9'h020;
  localparam logic [8:0] RRN  = 9'h040, RD   = 9'h080;
  localparam logic [8:0] WR   = 9'h100;

  tag_sequencer dut (
    .bitclk(bitclk), .reset(reset), .cmd_in(cmd_in),
    .packet_complete(packet_complete), .crc_ok(crc_ok),
    .rn_match(rn_match), .q_in(q_in), .rng_in(rng_in),
    .tx_done(tx_done), .state(state), .slot(slot),
    .tx_start(tx_start), .tx_sel(tx_sel), .tx_busy(tx_busy),
    .rx_reset(rx_reset)
  );

  always #5 bitclk = ~bitclk;

  // ---------------- behavioural model ----------------
  int  m_state, m_slot, m_sel;
  bit  m_start, m_busy, m_rx, m_pc, m_valid;

  task automatic m_send(input int sel);
    m_start = 1'b1;
    m_sel   = sel;
  endtask

  task automatic m_query();
    int ns;
    ns = int'(rng_in[14:0]) % (1 << q_in);
    m_slot = ns;
    if (ns == 0) begin
      m_state = 2;
      m_send(0);
    end else m_state = 1;
  endtask

  task automatic m_cmd(input int c);
    case (c)
      0: begin
        if (m_state == 1) begin
          m_slot = (m_slot + 32767) % 32768;
          if (m_slot == 0) begin
            m_state = 2;
            m_send(0);
          end
        end else if (m_state == 2) begin
          m_state = 1;
          m_slot = 32767;
        end else if (m_state >= 3) m_state = 0;
      end
      1: begin
        if (rn_match && (m_state == 2 || m_state == 3)) begin
          m_state = 3;
          m_send(1);
        end else if (m_state == 2) m_state = 1;
      end
      2: m_query();
      3: begin
        if (m_state == 1 || m_state == 2) m_query();
        else if (m_state >= 3) m_state = 0;
      end
      4: m_state = 0;
      5: if (m_state >= 2) m_state = 1;
      6: begin
        if (rn_match && m_state == 3) begin
          m_state = 4;
          m_send(2);
        end else if (rn_match && m_state == 4) m_send(0);
      end
      7: if (rn_match && m_state == 4) m_send(3);
      8: if (rn_match && m_state == 4) m_send(4);
      default: ;
    endcase
  endtask

  always @(posedge bitclk) begin
    bit ev, nb;
    int idx;
    if (reset) begin
      m_state = 0; m_slot = 0; m_sel = 0;
      m_start = 0; m_busy = 0; m_rx = 0; m_pc = 0;
      m_valid = 1;
    end else if (m_valid) begin
      ev = packet_complete && !m_pc;
      nb = m_start ? 1'b1 : (tx_done ? 1'b0 : m_busy);
      m_start = 0;
      m_rx = ev;
      if (ev && crc_ok && $countones(cmd_in) == 1 && !m_busy) begin
        idx = 0;
        for (int i = 0; i < 9; i++) if (cmd_in[i]) idx = i;
        m_cmd(idx);
      end
      m_busy = nb;
      m_pc = packet_complete;
    end
  end

  task automatic cmp(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Compare process: every cycle once the model has seen reset
  always @(negedge bitclk) begin
    if (m_valid) begin
      cmp("state", int'(state), m_state);
      cmp("slot", int'(slot), m_slot);
      cmp("tx_start", int'(tx_start), int'(m_start));
      cmp("tx_sel", int'(tx_sel), m_sel);
      cmp("tx_busy", int'(tx_busy), int'(m_busy));
      cmp("rx_reset", int'(rx_reset), int'(m_rx));
    end
  end

  // ---------------- directed stimulus ----------------
  int s_state, s_slot, s_start, s_sel, s_rx;

  task automatic tick();
    @(posedge bitclk);
    #1;
  endtask

  task automatic pkt(input logic [8:0] c, input logic crc,
                     input logic m, input logic [3:0] q,
                     input logic [15:0] r, input logic d);
    cmd_in = c; crc_ok = crc; rn_match = m;
    q_in = q; rng_in = r; tx_done = d;
    packet_complete = 1'b1;
    tick();
    s_state = int'(state); s_slot = int'(slot);
    s_start = int'(tx_start); s_sel = int'(tx_sel);
    s_rx = int'(rx_reset);
    tx_done = 1'b0;
    tick();
    packet_complete = 1'b0;
    cmd_in = 9'd0;
    tick();
  endtask

  task automatic done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
  endtask

  task automatic lit(input string nm, input int st, input int sl,
                     input int stt, input int se);
    cmp({nm, ".state"}, s_state, st);
    cmp({nm, ".slot"}, s_slot, sl);
    cmp({nm, ".start"}, s_start, stt);
    cmp({nm, ".sel"}, s_sel, se);
    cmp({nm, ".rx"}, s_rx, 1);
  endtask

  initial begin
    reset = 1'b1; cmd_in = 9'd0; packet_complete = 1'b0;
    crc_ok = 1'b0; rn_match = 1'b0; q_in = 4'd0;
    rng_in = 16'd0; tx_done = 1'b0;
    tick(); tick();
    cmp("rst.state", int'(state), 0);
    cmp("rst.slot", int'(slot), 0);
    cmp("rst.sel", int'(tx_sel), 0);
    cmp("rst.busy", int'(tx_busy), 0);
    cmp("rst.rx", int'(rx_reset), 0);
    reset = 1'b0;
    tick();

    pkt(QRY, 1, 0, 4'd0, 16'h1234, 0); lit("q0", 2, 0, 1, 0);
    done();
    pkt(ACK, 1, 0, 4'd0, 16'h0, 0);    lit("acknm", 1, 0, 0, 0);

    pkt(QRY, 1, 0, 4'd2, 16'h0003, 0); lit("q2", 1, 3, 0, 0);
    pkt(QREP, 1, 0, 4'd0, 16'h0, 0);   lit("qr1", 1, 2, 0, 0);
    done();
    pkt(QREP, 1, 0, 4'd0, 16'h0, 0);   lit("qr2", 1, 1, 0, 0);
    done();
    pkt(QREP, 1, 0, 4'd0, 16'h0, 0);   lit("qr3", 2, 0, 1, 0);
    done();

    pkt(ACK, 1, 1, 4'd0, 16'h0, 0);    lit("ack", 3, 0, 1, 1);
    done();
    pkt(RRN, 1, 1, 4'd0, 16'h0, 0);    lit("rrn", 4, 0, 1, 2);
    done();
    pkt(RD, 1, 1, 4'd0, 16'h0, 0);     lit("read", 4, 0, 1, 3);
    done();

    pkt(QREP, 0, 1, 4'd0, 16'h0, 0);   lit("badcrc", 4, 0, 0, 3);
    pkt(9'h006, 1, 1, 4'd0, 16'h0, 0); lit("twohot", 4, 0, 0, 3);
    pkt(WR, 1, 1, 4'd0, 16'h0, 0);     lit("write", 4, 0, 1, 4);
    cmp("busy.hi", int'(tx_busy), 1);
    pkt(RD, 1, 1, 4'd0, 16'h0, 0);     lit("busyrej", 4, 0, 0, 4);
    done();
    pkt(WR, 1, 1, 4'd0, 16'h0, 0);     lit("write2", 4, 0, 1, 4);
    pkt(RD, 1, 1, 4'd0, 16'h0, 1);     lit("donerej", 4, 0, 0, 4);
    cmp("busy.lo", int'(tx_busy), 0);

    pkt(QREP, 1, 0, 4'd0, 16'h0, 0);   lit("openqr", 0, 0, 0, 4);
    pkt(QRY, 1, 0, 4'd1, 16'h0001, 0); lit("q1", 1, 1, 0, 4);
    pkt(QREP, 1, 0, 4'd0, 16'h0, 0);   lit("qr0", 2, 0, 1, 0);
    done();
    pkt(NAK, 1, 0, 4'd0, 16'h0, 0);    lit("nack", 1, 0, 0, 0);
    pkt(QREP, 1, 0, 4'd0, 16'h0, 0);   lit("wrap", 1, 32767, 0, 0);
    pkt(QADJ, 1, 0, 4'd15, 16'hFFFF, 0);
    lit("qadj15", 1, 32767, 0, 0);
    pkt(SEL, 1, 0, 4'd0, 16'h0, 0);    lit("select", 0, 32767, 0, 0);
    pkt(QADJ, 1, 0, 4'd0, 16'h0, 0);   lit("qadjrdy", 0, 32767, 0, 0);

    pkt(QRY, 1, 0, 4'd0, 16'h0, 0);
    done();
    pkt(ACK, 1, 1, 4'd0, 16'h0, 0);
    done();
    pkt(RRN, 1, 1, 4'd0, 16'h0, 0);
    done();
    pkt(RD, 1, 1, 4'd0, 16'h0, 0);     lit("read2", 4, 0, 1, 3);
    cmp("pre.busy", int'(tx_busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("rstmid.state", int'(state), 0);
    cmp("rstmid.busy", int'(tx_busy), 0);
    cmp("rstmid.sel", int'(tx_sel), 0);
    done();
    cmp("late.state", int'(state), 0);
    cmp("late.busy", int'(tx_busy), 0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
